// File: rtl/chiplib_pkg.sv
// Shared types and helpers for the chiplib stream cells.
package chiplib_pkg;

  localparam int DST_W   = 2;
  localparam int MAX_OUT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } demux_state_e;

  // Increment that holds at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    logic [31:0] r;
    if (v == max_v) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/chiplib_skid2.sv
// Two-entry valid/ready register slice: outputs and in_ready are registered.
module chiplib_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_r, skid_valid_r, in_ready_r;
  logic [W-1:0] main_data_r, skid_data_r;
  logic         main_valid_n, skid_valid_n;
  logic [W-1:0] main_data_n, skid_data_n;
  logic         accept_s, take_s;

  // Next-state for main/skid; a held skid entry always drains before new input.
  always_comb begin
    accept_s     = in_valid & in_ready_r;
    take_s       = main_valid_r & out_ready;
    main_valid_n = main_valid_r;
    main_data_n  = main_data_r;
    skid_valid_n = skid_valid_r;
    skid_data_n  = skid_data_r;
    if (take_s || !main_valid_r) begin
      if (skid_valid_r) begin
        main_valid_n = 1'b1;
        main_data_n  = skid_data_r;
        skid_valid_n = 1'b0;
      end else if (accept_s) begin
        main_valid_n = 1'b1;
        main_data_n  = in_data;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (accept_s) begin
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
    end else begin
      skid_valid_n = skid_valid_r;
    end
  end

  // Slice registers; in_ready is precomputed from the next skid occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b0;
      main_data_r  <= '0;
      skid_data_r  <= '0;
    end else begin
      main_valid_r <= main_valid_n;
      skid_valid_r <= skid_valid_n;
      in_ready_r   <= ~skid_valid_n;
      main_data_r  <= main_data_n;
      skid_data_r  <= skid_data_n;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = main_valid_r;
  assign out_data  = main_data_r;

endmodule

// File: rtl/chiplib_demux4_stream.sv
// 1-to-NUM_OUT packet demux: destination locked per packet, invalid destinations dropped.
module chiplib_demux4_stream
  import chiplib_pkg::*;
#(
  parameter int DW      = 32,
  parameter int NUM_OUT = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  input  logic [DST_W-1:0]   in_dst,
  input  logic               in_last,
  output logic [MAX_OUT-1:0] out_valid,
  input  logic [MAX_OUT-1:0] out_ready,
  output logic [DW-1:0]      out_data,
  output logic               out_last,
  output logic               drop_pulse,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int PW = DST_W + 1 + DW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  demux_state_e     state_r, state_n;
  logic [DST_W-1:0] dst_r, dst_n, fwd_dst_s, main_dst_s;
  logic             in_ready_s, accept_s, drop_s, dst_bad_s, main_valid_s, sel_ready_s;
  logic [PW-1:0]    main_s;
  logic [MAX_OUT-1:0] out_valid_s;
  logic             drop_pulse_r;
  logic [CNT_W-1:0] drop_cnt_r;

  // Packet FSM: decides drop vs. forward and which destination the beat carries.
  always_comb begin
    dst_bad_s = (int'(in_dst) >= NUM_OUT);
    accept_s  = in_valid & in_ready_s;
    state_n   = state_r;
    dst_n     = dst_r;
    drop_s    = 1'b0;
    fwd_dst_s = dst_r;
    case (state_r)
      ST_IDLE: begin
        drop_s    = dst_bad_s;
        fwd_dst_s = in_dst;
        if (accept_s) begin
          dst_n = in_dst;
          if (in_last) begin
            state_n = ST_IDLE;
          end else if (dst_bad_s) begin
            state_n = ST_DROP;
          end else begin
            state_n = ST_FWD;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_FWD: begin
        if (accept_s && in_last) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_FWD;
        end
      end
      ST_DROP: begin
        drop_s = 1'b1;
        if (accept_s && in_last) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_DROP;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // FSM state and locked destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      dst_r   <= '0;
    end else begin
      state_r <= state_n;
      dst_r   <= dst_n;
    end
  end

  // Drop reporting: pulse and saturating counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse_r <= 1'b0;
      drop_cnt_r   <= '0;
    end else begin
      drop_pulse_r <= accept_s & drop_s;
      if (accept_s && drop_s) begin
        drop_cnt_r <= CNT_W'(sat_inc(32'(drop_cnt_r), 32'(CNT_MAX)));
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  // Dropped beats are masked here so they never occupy the slice.
  chiplib_skid2 #(.W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & ~drop_s),
    .in_ready  (in_ready_s),
    .in_data   ({fwd_dst_s, in_last, in_data}),
    .out_valid (main_valid_s),
    .out_ready (sel_ready_s),
    .out_data  (main_s)
  );

  assign main_dst_s  = main_s[PW-1 -: DST_W];
  assign sel_ready_s = out_ready[main_dst_s];

  // One-hot valid decode of the main entry's destination.
  always_comb begin
    out_valid_s = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      out_valid_s[i] = main_valid_s && (int'(main_dst_s) == i) && (i < NUM_OUT);
    end
  end

  assign out_valid  = out_valid_s;
  assign out_data   = main_s[DW-1:0];
  assign out_last   = main_s[DW];
  assign in_ready   = in_ready_s;
  assign drop_pulse = drop_pulse_r;
  assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_chiplib_demux4_stream.sv
// Directed bench for chiplib_demux4_stream built with NUM_OUT=3, CNT_W=2.
module tb_chiplib_demux4_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last, out_last, drop_pulse;
  logic [31:0] in_data, out_data;
  logic [1:0]  in_dst, drop_cnt;
  logic [3:0]  out_valid, out_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int n_drop   = 0;
  int bad_oh   = 0;
  int rd       = 0;
  logic [34:0] got_q[$];
  logic [34:0] exp_q[$];

  always #5 clk = ~clk;

  chiplib_demux4_stream #(.DW(32), .NUM_OUT(3), .CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dst     (in_dst),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .drop_pulse (drop_pulse),
    .drop_cnt   (drop_cnt)
  );

  // Log every sink transfer as {sink, last, data}; watch one-hot and drop pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(out_valid) > 1 || out_valid[3]) bad_oh++;
      if (drop_pulse) n_drop++;
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) got_q.push_back({i[1:0], out_last, out_data});
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] d, input logic [31:0] data, input logic last);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1; in_dst = d; in_data = data; in_last = last;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk("send_accepted", acc, 1);
  endtask

  task automatic cmp_q(input string tag);
    int idx;
    chk({tag, "_count"}, got_q.size() - rd, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      idx = rd + i;
      if (idx < got_q.size()) chk(tag, got_q[idx], exp_q[i]);
      else chk(tag, 64'hdead, exp_q[i]);
    end
    rd = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    int d0;
    logic [31:0] d;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dst = '0; in_last = 1'b0;
    out_ready = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_drop_pulse", drop_pulse, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", in_ready, 0);
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    cyc(1);

    // Single-beat packet to sink 2.
    send(2'd2, 32'hA5A5A5A5, 1'b1);
    @(negedge clk);
    chk("t1_valid", out_valid, 4'b0100);
    chk("t1_data", out_data, 32'hA5A5A5A5);
    chk("t1_last", out_last, 1);
    cyc(2);
    exp_q.push_back({2'd2, 1'b1, 32'hA5A5A5A5});
    cmp_q("t1_beats");

    // Destination locked on the first beat; later in_dst=3 ignored.
    for (int k = 0; k < 4; k++) begin
      d = 32'h10000000 + 32'(k);
      send((k == 0) ? 2'd1 : 2'd3, d, (k == 3));
      exp_q.push_back({2'd1, (k == 3), d});
    end
    cyc(3);
    cmp_q("t2_beats");

    // Invalid destination 3 drops the whole packet.
    d0 = n_drop;
    send(2'd3, 32'h33333330, 1'b0);
    send(2'd3, 32'h33333331, 1'b0);
    chk("t3_cnt2", drop_cnt, 2);
    send(2'd3, 32'h33333332, 1'b1);
    cyc(2);
    chk("t3_cnt3", drop_cnt, 3);
    chk("t3_pulses", n_drop - d0, 3);
    cmp_q("t3_none");
    send(2'd0, 32'h12345678, 1'b1);
    cyc(2);
    exp_q.push_back({2'd0, 1'b1, 32'h12345678});
    cmp_q("t3_next");

    // Backpressure on sink 0 for several cycles mid-stream.
    out_ready = 4'b1110;
    fork
      begin
        for (int k = 0; k < 6; k++) send(2'd0, 32'hB0000000 + 32'(k), (k == 5));
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t4_ready_low", in_ready, 0);
        chk("t4_hold_valid", out_valid, 4'b0001);
        chk("t4_hold_data", out_data, 32'hB0000000);
        repeat (3) @(posedge clk);
        #1 out_ready = 4'b1111;
      end
    join
    cyc(3);
    for (int k = 0; k < 6; k++) exp_q.push_back({2'd0, (k == 5), 32'hB0000000 + 32'(k)});
    cmp_q("t4_beats");

    // Packet B to sink 2 queued behind stalled single-beat A to sink 0.
    out_ready = 4'b1110;
    send(2'd0, 32'hC0C0C0C0, 1'b1);
    send(2'd2, 32'hC1C1C1C1, 1'b1);
    cyc(3);
    @(negedge clk);
    chk("t5_valid", out_valid, 4'b0001);
    chk("t5_data", out_data, 32'hC0C0C0C0);
    chk("t5_ready", in_ready, 0);
    @(posedge clk); #1 out_ready = 4'b1111;
    cyc(3);
    exp_q.push_back({2'd0, 1'b1, 32'hC0C0C0C0});
    exp_q.push_back({2'd2, 1'b1, 32'hC1C1C1C1});
    cmp_q("t5_beats");

    // Drop counter saturates.
    d0 = n_drop;
    for (int k = 0; k < 5; k++) send(2'd3, 32'(k), 1'b1);
    cyc(2);
    chk("t6_sat", drop_cnt, 3);
    chk("t6_pulses", n_drop - d0, 5);

    // Reset in the middle of a forwarded packet.
    send(2'd1, 32'hE0E0E0E0, 1'b0);
    send(2'd1, 32'hE1E1E1E1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t7_valid", out_valid, 4'b0000);
    chk("t7_data", out_data, 0);
    chk("t7_last", out_last, 0);
    chk("t7_ready", in_ready, 0);
    chk("t7_cnt", drop_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(2);
    rd = got_q.size();
    send(2'd2, 32'hF0F0F0F0, 1'b1);
    cyc(2);
    exp_q.push_back({2'd2, 1'b1, 32'hF0F0F0F0});
    cmp_q("t7_fresh");

    chk("onehot", bad_oh, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
